// File: rtl/synfifo_pkg.sv
// Shared definitions for synfifo and its read-side streaming companion.
// Holds the data width default, the reader state encoding and its next-state rule.
package synfifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Flush wins over en; DRAIN lingers until the last issued read has landed.
    function automatic state_e fsm_next(input state_e cur, input logic en,
                                        input logic flush, input logic inflight);
        state_e nxt;
        nxt = cur;
        if (flush) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE:    if (en) nxt = RUN;   else nxt = IDLE;
                RUN:     if (en) nxt = RUN;   else nxt = DRAIN;
                DRAIN:   if (en) nxt = RUN;   else if (!inflight) nxt = IDLE; else nxt = DRAIN;
                default: nxt = IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/synfifo_rd_stream_if.sv
// Bundles the synfifo read port and the downstream valid/ready stream.
// master = the reader block, slave = synfifo plus downstream consumer.
interface synfifo_rd_stream_if
    import synfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_vld;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty, fifo_rd_data, fifo_rd_vld, m_ready,
        output fifo_rd, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_rd_data, fifo_rd_vld, m_ready,
        input  fifo_rd, m_valid, m_data
    );
endinterface

// File: rtl/synfifo_rd_buf.sv
// Small circular register buffer holding words drained from synfifo.
// clr empties it on the next edge and takes priority over push/pop.
module synfifo_rd_buf
    import synfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 2,
    parameter int BUF_AW     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [BUF_AW:0]       count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [BUF_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BUF_AW:0]       count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/synfifo_rd_stream.sv
// Drains synfifo (1-cycle read latency) into a local buffer and re-presents it as a
// valid/ready stream, with enable/drain, flush, error flag and transfer counter.
module synfifo_rd_stream
    import synfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 2,
    parameter int BUF_AW     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                flush,
    synfifo_rd_stream_if.master bus,
    output logic                busy,
    output logic                err_unexp,
    output logic [31:0]         xfer_cnt
);

    localparam logic [BUF_AW+1:0] DEPTH_L = (BUF_AW+2)'(BUF_DEPTH);

    state_e              state_q, state_d;
    logic                inflight_q, inflight_d;
    logic                discard_q, discard_d;
    logic                err_q, err_d;
    logic [31:0]         xfer_q, xfer_d;
    logic [BUF_AW:0]     count_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [BUF_AW+1:0]   occupancy_s;
    logic                fifo_rd_s, m_valid_s, accept_s, push_s;

    // Issue, capture and bookkeeping; occupancy counts the read in flight so the buffer cannot overflow.
    always_comb begin
        occupancy_s = {1'b0, count_s} + {{(BUF_AW+1){1'b0}}, inflight_q};
        fifo_rd_s   = (state_q == RUN) & ~bus.fifo_empty & ~flush & (occupancy_s < DEPTH_L);
        m_valid_s   = (count_s != '0);
        accept_s    = m_valid_s & bus.m_ready;
        push_s      = bus.fifo_rd_vld & inflight_q & ~discard_q & ~flush;
        state_d     = fsm_next(state_q, en, flush, inflight_q);
        case ({fifo_rd_s, bus.fifo_rd_vld})
            2'b10:   inflight_d = 1'b1;
            2'b01:   inflight_d = 1'b0;
            default: inflight_d = inflight_q;
        endcase
        if (flush) begin
            discard_d = inflight_q & ~bus.fifo_rd_vld;
        end else if (bus.fifo_rd_vld) begin
            discard_d = 1'b0;
        end else begin
            discard_d = discard_q;
        end
        err_d = err_q | (bus.fifo_rd_vld & ~inflight_q);
        if (accept_s) begin
            xfer_d = xfer_q + 32'd1;
        end else begin
            xfer_d = xfer_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            err_q      <= 1'b0;
            xfer_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
            xfer_q     <= xfer_d;
        end
    end

    synfifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .BUF_AW     (BUF_AW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (push_s),
        .push_data (bus.fifo_rd_data),
        .pop       (accept_s),
        .count     (count_s),
        .head      (head_s)
    );

    assign bus.fifo_rd = fifo_rd_s;
    assign bus.m_valid = m_valid_s;
    assign bus.m_data  = head_s;
    assign busy        = (state_q != IDLE) | (count_s != '0) | inflight_q;
    assign err_unexp   = err_q;
    assign xfer_cnt    = xfer_q;

endmodule

// File: tb/tb_synfifo_rd_stream.sv
// Scoreboard bench: a synfifo model feeds the DUT, expected words are queued at load
// time and a negedge monitor compares every accepted output word in order.
module tb_synfifo_rd_stream;

    logic        clk, rst, en, flush, m_ready, spur_vld;
    logic        busy, err_unexp;
    logic [31:0] xfer_cnt;

    synfifo_rd_stream_if #(.DATA_WIDTH(32)) bus ();

    synfifo_rd_stream #(.DATA_WIDTH(32), .BUF_DEPTH(2), .BUF_AW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .bus       (bus),
        .busy      (busy),
        .err_unexp (err_unexp),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synfifo model: registered read data, one cycle after rd.
    logic [31:0] fmem [0:127];
    int          wp = 0;
    int          rp = 0;
    logic [31:0] mdata;
    logic        mvld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rp    <= wp;
            mvld  <= 1'b0;
            mdata <= 32'd0;
        end else if (bus.fifo_rd) begin
            mdata <= fmem[rp[6:0]];
            rp    <= rp + 1;
            mvld  <= 1'b1;
        end else begin
            mvld  <= 1'b0;
        end
    end

    assign bus.fifo_empty   = (wp == rp);
    assign bus.fifo_rd_data = mdata;
    assign bus.fifo_rd_vld  = mvld | spur_vld;
    assign bus.m_ready      = m_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_pulses = 0;
    logic [31:0] exp_q [$];
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [31:0] v, input bit expect_out);
        fmem[wp[6:0]] = v;
        wp = wp + 1;
        if (expect_out) exp_q.push_back(v);
    endtask

    task automatic wait_out(input string nm, input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) tick(1);
        chk(nm, exp_q.size(), 32'd0);
    endtask

    // Output monitor: in-order scoreboard, hold-while-stalled check, read strobe count.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fifo_rd) rd_pulses++;
            if (stall_prev && bus.m_valid) chk("hold_data", bus.m_data, data_prev);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_word: got %0h, expected no word", bus.m_data);
                end else begin
                    chk("out_word", bus.m_data, exp_q.pop_front());
                end
            end
            stall_prev = bus.m_valid & ~bus.m_ready;
            data_prev  = bus.m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    int snap;

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0; spur_vld = 1'b0;
        tick(2);
        chk("rst_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_data", bus.m_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_unexp}, 32'd0);
        chk("rst_xfer", xfer_cnt, 32'd0);
        rst = 1'b0;
        tick(1);

        // Continuous drain of 32 words.
        for (int i = 0; i < 32; i++) load(32'(i), 1'b1);
        m_ready = 1'b1;
        en = 1'b1;
        wait_out("cont_timeout", 200);
        tick(1);
        chk("cont_xfer", xfer_cnt, 32'd32);
        chk("cont_busy_run", {31'd0, busy}, 32'd1);
        en = 1'b0;
        tick(4);
        chk("cont_busy_idle", {31'd0, busy}, 32'd0);

        // Backpressure: 8 words, stalled for 10 cycles.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(32'h100 + 32'(i), 1'b1);
        snap = rd_pulses;
        en = 1'b1;
        tick(10);
        chk("bp_rd_pulses", 32'(rd_pulses - snap), 32'd2);
        chk("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("bp_head", bus.m_data, 32'h100);
        m_ready = 1'b1;
        wait_out("bp_timeout", 100);
        tick(1);
        chk("bp_rd_total", 32'(rd_pulses - snap), 32'd8);
        chk("bp_xfer", xfer_cnt, 32'd40);
        en = 1'b0;
        tick(4);

        // Flush with one word buffered and one landing.
        m_ready = 1'b0;
        load(32'hA0, 1'b0);
        load(32'hA1, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 20 && !bus.m_valid; i++) tick(1);
        chk("fl_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        flush = 1'b1;
        en = 1'b0;
        tick(1);
        flush = 1'b0;
        chk("fl_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("fl_busy", {31'd0, busy}, 32'd0);
        tick(3);
        chk("fl_err", {31'd0, err_unexp}, 32'd0);
        chk("fl_m_valid_late", {31'd0, bus.m_valid}, 32'd0);
        chk("fl_fifo_empty", {31'd0, bus.fifo_empty}, 32'd1);
        chk("fl_xfer", xfer_cnt, 32'd40);

        // en falls in the same cycle as a read strobe.
        m_ready = 1'b1;
        load(32'hD0, 1'b1);
        load(32'hD1, 1'b0);
        snap = rd_pulses;
        en = 1'b1;
        tick(1);
        chk("dr_rd_now", {31'd0, bus.fifo_rd}, 32'd1);
        en = 1'b0;
        tick(6);
        chk("dr_rd_pulses", 32'(rd_pulses - snap), 32'd1);
        chk("dr_out_left", exp_q.size(), 32'd0);
        chk("dr_busy", {31'd0, busy}, 32'd0);
        chk("dr_xfer", xfer_cnt, 32'd41);
        chk("dr_err", {31'd0, err_unexp}, 32'd0);

        // Spurious read-valid while idle.
        m_ready = 1'b0;
        spur_vld = 1'b1;
        tick(1);
        spur_vld = 1'b0;
        chk("sp_err", {31'd0, err_unexp}, 32'd1);
        chk("sp_m_valid", {31'd0, bus.m_valid}, 32'd0);
        tick(3);
        chk("sp_err_sticky", {31'd0, err_unexp}, 32'd1);
        chk("sp_m_valid_late", {31'd0, bus.m_valid}, 32'd0);

        // Asynchronous reset with a full buffer.
        load(32'hE0, 1'b0);
        en = 1'b1;
        tick(8);
        chk("ar_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("ar_pre_head", bus.m_data, 32'hD1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);
        chk("ar_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("ar_m_data", bus.m_data, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_err", {31'd0, err_unexp}, 32'd0);
        chk("ar_xfer", xfer_cnt, 32'd0);
        en = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
